// File: rtl/run_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_pattern_pkg
// Description : Shared types and constants for the run-pattern generator.
//               FSM state encoding, datapath widths, LFSR feedback polynomial
//               and the request-length saturation helper.
// Revision    : 1.0  initial release
// ============================================================================
package run_pattern_pkg;

    localparam int          WORD_W    = 8;
    localparam int          LEN_W     = 4;
    localparam int          LFSR_W    = 16;
    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        BUILD  = 2'd2,
        HOLD   = 2'd3
    } rpg_state_t;

    // Requests longer than the word saturate to a full word of ones.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        return (len > 4'd8) ? 4'd8 : len;
    endfunction

endpackage : run_pattern_pkg
`default_nettype wire

// File: rtl/run_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : run_lfsr
// Description : Free-running 16-bit Galois LFSR. Steps every cycle. A zero
//               seed would lock the register, so it is replaced by 16'h0001.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset (loads seed)
//               seed  - reset value
//               q     - current LFSR state
// Revision    : 1.0  initial release
// ============================================================================
module run_lfsr
    import run_pattern_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] w_seed;
    logic [LFSR_W-1:0] r_q;

    assign w_seed = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= w_seed;
        end else begin
            r_q <= {1'b0, r_q[LFSR_W-1:1]} ^ (r_q[0] ? LFSR_TAPS : '0);
        end
    end

    assign q = r_q;

endmodule : run_lfsr
`default_nettype wire

// File: rtl/run_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : run_pattern_gen
// Description : Generates an 8-bit word whose longest run of consecutive ones
//               is exactly the requested length L (0..8, larger saturates).
//               The run position and filler bits are drawn from an LFSR.
//               Optional feature macro: RUN_PATTERN_SELFCHECK_EN enables a
//               longest-run tracker that sets the sticky chk_err flag when
//               the produced word does not match L; otherwise chk_err is 0.
// Ports       : clk, rst_n           - clock / async active-low reset
//               req_valid/req_ready  - request handshake, req_len length
//               out_valid/out_ready  - result handshake
//               out_word, out_len    - generated pattern and produced length
//               chk_err              - sticky self-check mismatch flag
// Revision    : 1.0  initial release
// ============================================================================
module run_pattern_gen
    import run_pattern_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int unsigned MAX_RETRY = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [LEN_W-1:0]  req_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic [LEN_W-1:0]  out_len,
    output logic              chk_err
);

    localparam logic [7:0] c_max_retry = MAX_RETRY[7:0];

    rpg_state_t         r_state;
    rpg_state_t         w_state_nxt;

    logic [LFSR_W-1:0]  w_lfsr;
    logic               w_unused_lfsr;

    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_pos;
    logic [2:0]         r_idx;
    logic [LEN_W-1:0]   r_run_cnt;
    logic [7:0]         r_retry;
    logic [WORD_W-1:0]  r_word;

    logic [LEN_W-1:0]   w_len_sat;
    logic               w_accept;
    logic               w_direct;
    logic               w_pos_ok;
    logic               w_retry_exh;
    logic [3:0]         w_idx4;
    logic [3:0]         w_pos4;
    logic [3:0]         w_win_hi;
    logic               w_in_win;
    logic               w_nbr;
    logic               w_fill;
    logic               w_bit;
    logic [LEN_W-1:0]   w_run_nxt;

    run_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (SEED),
        .q     (w_lfsr)
    );

    // Only the low bits feed the datapath; the rest just keep the sequence long.
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:3];

    assign w_len_sat   = sat_len(req_len);
    assign w_accept    = req_valid && (r_state == IDLE);
    // L==0 and L==8 have only one legal position, so the draw is skipped.
    assign w_direct    = (w_len_sat == 4'd0) || (w_len_sat == 4'd8);
    assign w_pos_ok    = ({1'b0, w_lfsr[2:0]} <= (4'd8 - r_len));
    assign w_retry_exh = (r_retry == c_max_retry);

    // Bit decision for the current index. p+L never exceeds 8, so 4 bits hold it.
    assign w_idx4    = {1'b0, r_idx};
    assign w_pos4    = {1'b0, r_pos};
    assign w_win_hi  = w_pos4 + r_len;
    assign w_in_win  = (w_idx4 >= w_pos4) && (w_idx4 < w_win_hi);
    assign w_nbr     = (w_idx4 == w_win_hi) || ((r_pos != 3'd0) && (r_idx == r_pos - 3'd1));
    // A filler bit may not complete a run of length L outside the window.
    assign w_fill    = w_lfsr[0] && (r_len != 4'd0) && (r_run_cnt != r_len - 4'd1);
    assign w_bit     = w_in_win ? 1'b1 : (w_nbr ? 1'b0 : w_fill);
    assign w_run_nxt = w_bit ? (r_run_cnt + 4'd1) : 4'd0;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_state_nxt = w_direct ? BUILD : SELECT;
                end
            end
            SELECT: begin
                if (w_retry_exh || w_pos_ok) begin
                    w_state_nxt = BUILD;
                end
            end
            BUILD: begin
                if (r_idx == 3'd0) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_pos     <= '0;
            r_idx     <= 3'd7;
            r_run_cnt <= '0;
            r_retry   <= '0;
            r_word    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_len     <= w_len_sat;
                        r_pos     <= '0;
                        r_retry   <= '0;
                        r_idx     <= 3'd7;
                        r_run_cnt <= '0;
                        if (w_direct) begin
                            r_word <= '0;
                        end
                    end
                end
                SELECT: begin
                    if (w_retry_exh) begin
                        r_pos  <= '0;
                        r_word <= '0;
                    end else if (w_pos_ok) begin
                        r_pos  <= w_lfsr[2:0];
                        r_word <= '0;
                    end else begin
                        r_retry <= r_retry + 8'd1;
                    end
                end
                BUILD: begin
                    r_word[r_idx] <= w_bit;
                    r_run_cnt     <= w_run_nxt;
                    r_idx         <= r_idx - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_word = r_word;
    assign out_len  = r_len;

`ifdef RUN_PATTERN_SELFCHECK_EN
    logic [LEN_W-1:0] r_max_run;
    logic [LEN_W-1:0] w_max_nxt;
    logic             r_chk_err;

    assign w_max_nxt = (w_run_nxt > r_max_run) ? w_run_nxt : r_max_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_run <= '0;
            r_chk_err <= 1'b0;
        end else if (r_state == BUILD) begin
            r_max_run <= w_max_nxt;
            // Last bit: w_max_nxt is the longest run of the finished word.
            if ((r_idx == 3'd0) && (w_max_nxt != r_len)) begin
                r_chk_err <= 1'b1;
            end
        end else begin
            r_max_run <= '0;
        end
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif

endmodule : run_pattern_gen
`default_nettype wire

// File: tb/tb_run_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_pattern_gen
// Description : Self-checking bench for run_pattern_gen. Requests are pushed
//               into a scoreboard queue when accepted; a monitor checks each
//               delivered word against the longest-run rule, latency bounds
//               and any exact expected word.
// Revision    : 1.0  initial release
// ============================================================================
module tb_run_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_len;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic [3:0] out_len;
    logic       chk_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit rdy_rand = 0;

    typedef struct {
        int         len;
        int         t_acc;
        int         mode;   // 0: rule only, 1: exact word, 2: 8'hFE or 8'h7F
        logic [7:0] word;
    } exp_t;

    exp_t sb[$];

    run_pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_len   (out_len),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_true(input string nm, input bit ok, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        chk_true(nm, act == req, act, req);
    endtask

    function automatic int longest(input logic [7:0] w);
        int best = 0;
        int cur  = 0;
        for (int b = 0; b < 8; b++) begin
            if (w[b]) begin
                cur++;
                if (cur > best) best = cur;
            end else begin
                cur = 0;
            end
        end
        return best;
    endfunction

    // Random consumer back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor / scoreboard checker.
    initial begin
        bit   seen;
        exp_t e;
        int   lat;
        seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 0;
            end else begin
                if (out_valid && !seen) begin
                    seen = 1;
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        e   = sb[0];
                        lat = cyc - e.t_acc;
                        if (e.len == 0 || e.len == 8)
                            chk("latency_direct", lat, 9);
                        else
                            chk_true("latency_range", lat >= 10 && lat <= 17, lat, 17);
                    end
                end
                if (out_valid && out_ready && sb.size() != 0) begin
                    e    = sb.pop_front();
                    seen = 0;
                    chk("out_len", int'(out_len), e.len);
                    chk("longest_run", longest(out_word), e.len);
                    chk("chk_err", int'(chk_err), 0);
                    if (e.mode == 1)
                        chk("exact_word", int'(out_word), int'(e.word));
                    else if (e.mode == 2)
                        chk_true("word_fe_or_7f", out_word == 8'hFE || out_word == 8'h7F,
                                 int'(out_word), 8'h7F);
                end
            end
        end
    end

    task automatic send(input int len, input int mode, input logic [7:0] word);
        bit   ok;
        exp_t e;
        ok        = 0;
        req_len   = len[3:0];
        req_valid = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) begin
                e.len   = (len > 8) ? 8 : len;
                e.t_acc = cyc;
                e.mode  = mode;
                e.word  = word;
                sb.push_back(e);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w0;
        bit         got;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_len   = 4'd0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_word", int'(out_word), 0);
        chk("rst_out_len", int'(out_len), 0);
        chk("rst_chk_err", int'(chk_err), 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Boundary lengths
        send(0, 1, 8'h00);  wait_idle();
        send(8, 1, 8'hFF);  wait_idle();
        send(15, 1, 8'hFF); wait_idle();
        for (int r = 0; r < 6; r++) begin
            send(7, 2, 8'h00);
            wait_idle();
        end

        // Back-pressure in HOLD with a second request waiting
        out_ready = 1'b0;
        send(3, 0, 8'h00);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (out_valid) got = 1;
        end
        if (!got) chk("hold_timeout", 0, 1);
        w0 = out_word;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_len   = 4'd5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_word_stable", int'(out_word), int'(w0));
            chk("hold_req_ready", int'(req_ready), 0);
            chk("hold_out_valid", int'(out_valid), 1);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_hs_out_valid", int'(out_valid), 0);
        chk("post_hs_req_ready", int'(req_ready), 1);
        chk("post_hs_sb_empty", sb.size(), 0);

        // Asynchronous reset in the middle of BUILD (L=8, bit index 4)
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        req_len   = 4'd8;
        req_valid = 1'b1;
        @(negedge clk);
        chk("pre_acc_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("pre_rst_word", int'(out_word), 8'hE0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_word", int'(out_word), 0);
        chk("async_rst_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(2, 0, 8'h00);
        wait_idle();

        // Randomized traffic with consumer stalls
        rdy_rand = 1;
        for (int n = 0; n < 2000; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(int'($urandom_range(0, 15)), 0, 8'h00);
        end
        wait_idle();
        chk("final_chk_err", int'(chk_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_run_pattern_gen
`default_nettype wire
